// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter whose state is a bank of JK cells.
//
// Each cycle the next value is selected, in priority order, as:
// reset, then load, then count up or down, then hold.
// The per-bit J/K drive that moves the current state to that next value is then derived.
// The JK cells are updated from that drive.
//
// The J/K vectors are exported so an external bank of discrete JK flip-flops can run in
// lock-step with this block and be cross-checked against it.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high; clears count and gates j/k/tc low
//   en       in   count enable
//   up       in   direction: 1 = up, 0 = down
//   load     in   synchronous load strobe (overrides en)
//   load_val in   value to load; out-of-range values load 0
//   count    out  current counter state (registered)
//   j_vec    out  per-bit J drive for the next edge (combinational)
//   k_vec    out  per-bit K drive for the next edge (combinational)
//   tc       out  terminal count: high in the cycle before a wrap (combinational)
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc
);

    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the load range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_val;
    logic             at_max;
    logic             at_zero;

    always_comb begin
        at_max   = (count_q == MAX_VAL);
        at_zero  = (count_q == '0);
        next_val = count_q;
        if (load) begin
            next_val = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
        end else if (en) begin
            // The wrap decision is taken before the add/subtract, so no unused code is ever formed.
            if (up) begin
                next_val = at_max ? '0 : count_q + WIDTH'(1);
            end else begin
                next_val = at_zero ? MAX_VAL : count_q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        tc    = 1'b0;
        if (!rst) begin
            j_vec = next_val & ~count_q;
            k_vec = ~next_val & count_q;
            tc    = en & ~load & (up ? at_max : at_zero);
        end
    end

    // Full JK characteristic equation q+ = J~q | ~Kq.
    // This also covers the J=K=1 toggle case, which the drive logic never produces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= (j_vec & ~count_q) | (~k_vec & count_q);
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Testbench for jk_mod_counter (WIDTH=4, MODULUS=10).
//
// The driver applies one directed vector per clock, shortly after the rising edge.
// For each vector it pushes the hand-computed expectation for that cycle into a queue.
// The monitor pops one entry at each falling edge and compares count, j_vec, k_vec and tc.
//
// The monitor also keeps a reference JK bank clocked by the exported vectors.
// Each cycle it checks that this reference bank tracks count.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       tc;

    jk_mod_counter #(
        .WIDTH  (4),
        .MODULUS(10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .j_vec   (j_vec),
        .k_vec   (k_vec),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] cnt;
        logic [3:0] j;
        logic [3:0] k;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;

    task automatic cmp(input string nm, input int id, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", id, nm, got, want);
        end
    endtask

    // One vector for one cycle.
    // cur is the count visible during the cycle; nxt is the count after the coming edge.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [3:0] lv, input logic [3:0] cur, input logic [3:0] nxt,
                        input logic t);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        x.id  = row;
        x.cnt = cur;
        x.j   = r ? 4'b0000 : (nxt & ~cur);
        x.k   = r ? 4'b0000 : (~nxt & cur);
        x.tc  = t;
        row++;
        sb.push_back(x);
    endtask

    // Monitor: scoreboard pop plus reference JK bank cross-check.
    logic [3:0] ref_q = 4'd0;
    logic       ref_ok = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) ref_q = 4'd0;
            if (ref_ok) cmp("jk_xcheck", row, count, ref_q);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("count", e.id, count, e.cnt);
                cmp("j_vec", e.id, j_vec, e.j);
                cmp("k_vec", e.id, k_vec, e.k);
                cmp("tc", e.id, {3'b000, tc}, {3'b000, e.tc});
            end
            ref_q  = rst ? 4'd0 : ((j_vec & ~ref_q) | (~k_vec & ref_q));
            ref_ok = 1'b1;
        end
    end

    initial begin
        // Reset held.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        // Count up for 12 edges from 0: 1..9,0,1,2. tc only while count is 9.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i % 10), 4'((i + 1) % 10), (i % 10) == 9);
        end
        // Load 0 while enabled: load wins.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 4'd0, 1'b0);
        // Count down from 0: 9,8,7. tc while count is 0.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 4'd8, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 4'd7, 1'b0);
        // Reset raised mid-cycle at count 7 with a pending load.
        // Count clears before the next edge and the load is dropped.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        // Load 6 at count 0 going down: load suppresses the wrap and tc.
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 4'd0, 4'd6, 1'b0);
        // Out-of-range loads give 0.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 4'd6, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 4'd3, 1'b0);
        // Hold at 3 for 5 edges; direction toggles must not matter.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'(i % 2), 1'b0, 4'd0, 4'd3, 4'd3, 1'b0);
        end
        // Direction flip: 4 -> 5 (up), then 4 (down), then 3, with no dead cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd3, 4'd4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'd5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 4'd4, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 4'd3, 1'b0);
        // Load the top legal value 9, then wrap up to 0.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd3, 4'd9, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 4'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state is a bank of JK flip-flop cells.
- Each cycle the block computes per-bit J/K drive from the current state and the command inputs, then applies JK semantics internally.
- The computed J/K vectors are exported so a downstream bank of discrete JK_FF instances can be driven in lock-step and cross-checked.
- It is the J/K command stage that sits directly upstream of the JK flip-flop cells.

Parameters:
- WIDTH, 4, counter/state width in bits.
- MODULUS, 10, count sequence length; legal range 2..2**WIDTH; illegal values stop elaboration with an error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  count enable
- up  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current counter state (registered)
- j_vec  output  WIDTH  per-bit J drive for the next edge (combinational)
- k_vec  output  WIDTH  per-bit K drive for the next edge (combinational)
- tc  output  1  terminal-count flag (combinational)

Behaviour:
- Reset: rst high forces count=0 immediately, independent of clk.
  - While rst is high, j_vec=0, k_vec=0, tc=0.
  - On rst release, the first count change occurs at the first rising clk edge after deassertion.
- Next-state selection, in priority order: rst > load > en > hold.
  - load=1: next = load_val if load_val < MODULUS, else 0. Direction and en are ignored.
  - load=0, en=1, up=1: next = count+1, wrapping MODULUS-1 -> 0.
  - load=0, en=1, up=0: next = count-1, wrapping 0 -> MODULUS-1.
  - load=0, en=0: next = count.
- J/K generation, per bit i:
  - J_i = next_i & ~count_i.
  - K_i = ~next_i & count_i.
  - A held bit therefore gives J=K=0. J=K=1 is never produced.
- JK update at each rising edge, per bit:
  - J=0, K=0: hold.
  - J=1, K=0: set.
  - J=0, K=1: reset.
  - J=1, K=1: toggle. This case is implemented for completeness but is unreachable from the J/K generation above.
- Latency: count reflects the command one clock after it is sampled. j_vec, k_vec and tc follow the inputs in the same cycle (zero latency).
- tc = en & ~load & ~rst & (up ? count==MODULUS-1 : count==0). tc is high in the cycle before a wrap occurs.
- Width rules:
  - All arithmetic is WIDTH bits.
  - The wrap compare is made before the increment/decrement, so no overflow into unused codes occurs.
  - count never leaves the range 0..MODULUS-1.
- Simultaneous events:
  - load together with en: load wins and tc=0.
  - A direction change while enabled takes effect on the next edge with no dead cycle.
- Reset mid-operation: count is cleared asynchronously even between edges. A pending load is discarded.
- No X propagation: with rst asserted, every output is defined regardless of the other inputs.

Test Plan:
- Reset: rst=1 mid-cycle while count=7 -> count=0 before the next clk edge; j_vec=k_vec=0 and tc=0 while rst is held.
- Up count (en=1, up=1, 12 edges from 0) -> count 1,2,…,9,0,1,2.
  - tc=1 exactly while count=9.
  - At count=9: j_vec=4'b0000, k_vec=4'b1001.
- Down count (en=1, up=0, from 0) -> count 9,8,7.
  - tc=1 while count=0.
  - At count=0: j_vec=4'b1001, k_vec=4'b0000.
- Load:
  - load=1, load_val=6 with en=1 -> count=6 next edge, tc=0 in the load cycle.
  - load_val=12 (>= MODULUS) -> count=0.
- Hold, and per-edge cross-check against the exported vectors:
  - en=0 for 5 edges at count=3 -> count stays 3, j_vec=k_vec=0.
  - Cross-check: applying j_vec/k_vec to a reference JK model reproduces count on every edge.
- Direction flip: count=4 with up=1, then up=0 on the next cycle -> 5 then 4 on consecutive edges, no skipped or held cycle.
